// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit-level sequencer: command codes,
// FSM state encoding, default prescaler width and the per-phase line table.
// No ports (package only).
package i2c_pkg;

  localparam int PRESC_W_DEF = 16;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_STOP  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b100;

  // Phase states are numbered 1..4 so the last phase equals the phase count.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH_A = 3'd1,
    ST_PH_B = 3'd2,
    ST_PH_C = 3'd3,
    ST_PH_D = 3'd4
  } state_t;

  // Codes 101..111 behave as NOP.
  function automatic logic is_cmd(input logic [2:0] c);
    return (c == CMD_START) || (c == CMD_STOP) ||
           (c == CMD_WRITE) || (c == CMD_READ);
  endfunction

  function automatic state_t next_phase(input state_t s);
    state_t n;
    n = ST_IDLE;
    case (s)
      ST_PH_A: n = ST_PH_B;
      ST_PH_B: n = ST_PH_C;
      ST_PH_C: n = ST_PH_D;
      default: n = ST_IDLE;
    endcase
    return n;
  endfunction

  // Returns {scl_oen, sda_oen} for a command phase; 1 = line released.
  function automatic logic [1:0] line_lvl(input logic [2:0] c, input logic d,
                                          input state_t ph);
    logic [1:0] lvl;
    lvl = 2'b11;
    case (c)
      CMD_START:
        case (ph)
          ST_PH_C: lvl = 2'b10;
          ST_PH_D: lvl = 2'b00;
          default: lvl = 2'b11;
        endcase
      CMD_STOP:
        case (ph)
          ST_PH_A: lvl = 2'b00;
          ST_PH_B, ST_PH_C: lvl = 2'b10;
          default: lvl = 2'b11;
        endcase
      CMD_WRITE:
        case (ph)
          ST_PH_A, ST_PH_D: lvl = {1'b0, d};
          default: lvl = {1'b1, d};
        endcase
      CMD_READ:
        case (ph)
          ST_PH_A, ST_PH_D: lvl = 2'b01;
          default: lvl = 2'b11;
        endcase
      default: lvl = 2'b11;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/i2c_bit_ctrl_if.sv
// Command handshake plus bus-line bundle between the bit sequencer and its
// environment (byte controller above, line filter / pads below).
// slave = the sequencer; master = byte controller together with the line filter.
interface i2c_bit_ctrl_if;
  import i2c_pkg::*;

  logic [2:0] cmd;
  logic       cmd_valid;
  logic       din;
  logic       cmd_ack;
  logic       dout;
  logic       al;
  logic       busy;
  logic       start_det;
  logic       stop_det;
  logic       scl_i;
  logic       sda_i;
  logic       scl_oen;
  logic       sda_oen;

  modport slave (
    input  cmd, cmd_valid, din, scl_i, sda_i,
    output cmd_ack, dout, al, busy, start_det, stop_det, scl_oen, sda_oen
  );

  modport master (
    output cmd, cmd_valid, din, scl_i, sda_i,
    input  cmd_ack, dout, al, busy, start_det, stop_det, scl_oen, sda_oen
  );

endinterface

// File: rtl/i2c_bus_mon.sv
// Bus monitor: flags START/STOP conditions on the filtered lines and tracks busy.
// Latency: detect flags combinational from previous-cycle sda; busy 1 cycle later.
// Ports: clk, rst in; scl, sda filtered lines in; start_det, stop_det, busy out. No backpressure.
module i2c_bus_mon
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic start_det,
  output logic stop_det,
  output logic busy
);

  logic sda_d;

  // An SDA edge while SCL is high is a bus condition, never a data change.
  assign start_det = scl & sda_d & ~sda;
  assign stop_det  = scl & ~sda_d & sda;

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_d <= 1'b1;
      busy  <= 1'b0;
    end else begin
      sda_d <= sda;
      if (start_det)
        busy <= 1'b1;
      else if (stop_det)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C master: runs one START/STOP/WRITE/READ command as four timed phases.
// Latency: 4*(presc+1) enabled cycles per command plus stretch, then 1-cycle cmd_ack.
// Backpressure: accepts only in IDLE with cmd_ack low; ena=0 or SCL stretching holds.
// Ports: clk, rst (sync, active-high), ena, presc; bus (slave) carries cmd/cmd_valid/din,
// cmd_ack/dout/al/busy/start_det/stop_det, scl_i/sda_i and scl_oen/sda_oen.
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int PHASES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [PRESC_W-1:0] presc,
  i2c_bit_ctrl_if.slave      bus
);

  localparam state_t LAST_PH = state_t'(3'(PHASES));

  state_t             state;
  logic [PRESC_W-1:0] cnt;
  logic [2:0]         cmd_q;
  logic               din_q;
  logic               scl_q;
  logic               sda_q;
  logic               ack_q;
  logic               al_q;
  logic               dout_q;
  logic               stretch;
  logic               arb_lost;

  // A slave holding SCL low while we release it freezes the phase timer.
  assign stretch = scl_q & ~bus.scl_i;

  // We released SDA expecting high but someone else is driving it low.
  assign arb_lost = sda_q & ~bus.sda_i &
                    (((cmd_q == CMD_WRITE) && din_q &&
                      ((state == ST_PH_B) || (state == ST_PH_C))) ||
                     ((cmd_q == CMD_START) && (state == ST_PH_C)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      cmd_q  <= CMD_NOP;
      din_q  <= 1'b0;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
      ack_q  <= 1'b0;
      al_q   <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      al_q  <= 1'b0;
      if (ena) begin
        if (state == ST_IDLE) begin
          // ack_q gate enforces the one-cycle gap between commands.
          if (bus.cmd_valid && !ack_q && is_cmd(bus.cmd)) begin
            cmd_q          <= bus.cmd;
            din_q          <= bus.din;
            cnt            <= presc;
            state          <= ST_PH_A;
            {scl_q, sda_q} <= line_lvl(bus.cmd, bus.din, ST_PH_A);
          end
        end else if (arb_lost) begin
          al_q  <= 1'b1;
          scl_q <= 1'b1;
          sda_q <= 1'b1;
          cnt   <= '0;
          state <= ST_IDLE;
        end else if (!stretch) begin
          if (cnt != '0) begin
            cnt <= cnt - PRESC_W'(1);
          end else begin
            if ((state == ST_PH_C) && (cmd_q == CMD_READ))
              dout_q <= bus.sda_i;
            if (state == LAST_PH) begin
              // Lines keep their PH_D levels while idle.
              state <= ST_IDLE;
              ack_q <= 1'b1;
            end else begin
              state          <= next_phase(state);
              cnt            <= presc;
              {scl_q, sda_q} <= line_lvl(cmd_q, din_q, next_phase(state));
            end
          end
        end
      end
    end
  end

  assign bus.scl_oen = scl_q;
  assign bus.sda_oen = sda_q;
  assign bus.cmd_ack = ack_q;
  assign bus.al      = al_q;
  assign bus.dout    = dout_q;

  i2c_bus_mon u_bus_mon (
    .clk       (clk),
    .rst       (rst),
    .scl       (bus.scl_i),
    .sda       (bus.sda_i),
    .start_det (bus.start_det),
    .stop_det  (bus.stop_det),
    .busy      (bus.busy)
  );

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl with open-drain loopback of SCL/SDA;
// the bench can additionally pull either line low over chosen cycle windows.
module tb_i2c_bit_ctrl;
  import i2c_pkg::*;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [15:0] presc;
  logic        scl_pull;
  logic        sda_pull;

  int tests;
  int errs;

  logic scl_tr [0:255];
  logic sda_tr [0:255];
  logic al_seen;
  logic ack_seen;
  int   n;

  i2c_bit_ctrl_if bus ();

  // Wired-AND bus: a line is high only if nobody drives it low.
  assign bus.scl_i = bus.scl_oen & ~scl_pull;
  assign bus.sda_i = bus.sda_oen & ~sda_pull;

  i2c_bit_ctrl #(.PRESC_W(16), .PHASES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .presc (presc),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue a command and follow it cycle by cycle (cycle 1 = first PH_A cycle)
  // until cmd_ack or al; pull/ena windows are in those cycle numbers.
  task automatic run_cmd(input logic [2:0] c, input logic d,
                         input int sl_lo, input int sl_hi,
                         input int sd_lo, input int sd_hi,
                         input int en_lo, input int en_hi,
                         output int cycles);
    bus.cmd       = c;
    bus.din       = d;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cycles = 0;
    while (!bus.cmd_ack && !bus.al && cycles < 200) begin
      cycles++;
      scl_pull = (cycles >= sl_lo) && (cycles <= sl_hi);
      sda_pull = (cycles >= sd_lo) && (cycles <= sd_hi);
      ena      = !((cycles >= en_lo) && (cycles <= en_hi));
      scl_tr[cycles] = bus.scl_oen;
      sda_tr[cycles] = bus.sda_oen;
      @(negedge clk);
    end
    al_seen  = bus.al;
    scl_pull = 1'b0;
    sda_pull = 1'b0;
    ena      = 1'b1;
  endtask

  // Step past the ack/al cycle; both are single-cycle pulses.
  task automatic gap(input string tag);
    @(negedge clk);
    check({tag, "_ack_pulse"}, bus.cmd_ack, 0);
    check({tag, "_al_clear"}, bus.al, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests = 0;
    errs  = 0;
    rst = 1'b1; ena = 1'b1; presc = 16'd0;
    scl_pull = 1'b0; sda_pull = 1'b0;
    bus.cmd = CMD_NOP; bus.cmd_valid = 1'b0; bus.din = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_scl_oen", bus.scl_oen, 1);
    check("rst_sda_oen", bus.sda_oen, 1);
    check("rst_ack", bus.cmd_ack, 0);
    check("rst_al", bus.al, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // NOP codes are ignored: no ack, lines untouched.
    ack_seen = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd = CMD_NOP;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) bus.cmd = 3'b111;
      @(negedge clk);
      ack_seen |= bus.cmd_ack;
    end
    bus.cmd_valid = 1'b0;
    check("nop_no_ack", ack_seen, 0);
    check("nop_lines", {bus.scl_oen, bus.sda_oen}, 2'b11);
    @(negedge clk);

    // START then STOP, presc=3: 16 phase cycles each.
    presc = 16'd3;
    run_cmd(CMD_START, 1'b0, 0, 0, 0, 0, 0, 0, n);
    check("start_cycles", n, 16);
    check("start_ph_a", {scl_tr[1], sda_tr[1]}, 2'b11);
    check("start_ph_b", {scl_tr[5], sda_tr[5]}, 2'b11);
    check("start_ph_c", {scl_tr[9], sda_tr[9]}, 2'b10);
    check("start_ph_d", {scl_tr[13], sda_tr[13]}, 2'b00);
    check("start_busy", bus.busy, 1);
    gap("start");

    run_cmd(CMD_STOP, 1'b0, 0, 0, 0, 0, 0, 0, n);
    check("stop_cycles", n, 16);
    check("stop_ph_a", {scl_tr[1], sda_tr[1]}, 2'b00);
    check("stop_ph_b", {scl_tr[5], sda_tr[5]}, 2'b10);
    check("stop_ph_c", {scl_tr[9], sda_tr[9]}, 2'b10);
    check("stop_ph_d", {scl_tr[13], sda_tr[13]}, 2'b11);
    check("stop_busy", bus.busy, 0);
    gap("stop");

    // WRITE 0 and 1 with 1-cycle phases.
    presc = 16'd0;
    run_cmd(CMD_WRITE, 1'b0, 0, 0, 0, 0, 0, 0, n);
    check("wr0_cycles", n, 4);
    check("wr0_scl", {scl_tr[1], scl_tr[2], scl_tr[3], scl_tr[4]}, 4'b0110);
    check("wr0_sda", {sda_tr[1], sda_tr[2], sda_tr[3], sda_tr[4]}, 4'b0000);
    gap("wr0");
    run_cmd(CMD_WRITE, 1'b1, 0, 0, 0, 0, 0, 0, n);
    check("wr1_cycles", n, 4);
    check("wr1_scl", {scl_tr[1], scl_tr[2], scl_tr[3], scl_tr[4]}, 4'b0110);
    check("wr1_sda", {sda_tr[1], sda_tr[2], sda_tr[3], sda_tr[4]}, 4'b1111);
    gap("wr1");

    // READ, presc=1: free line, slave-driven 0, free line again.
    presc = 16'd1;
    run_cmd(CMD_READ, 1'b0, 0, 0, 0, 0, 0, 0, n);
    check("rd1_cycles", n, 8);
    check("rd1_dout", bus.dout, 1);
    check("rd1_scl", {scl_tr[1], scl_tr[3], scl_tr[5], scl_tr[7]}, 4'b0110);
    gap("rd1");
    run_cmd(CMD_READ, 1'b0, 0, 0, 1, 8, 0, 0, n);
    check("rd0_cycles", n, 8);
    check("rd0_dout", bus.dout, 0);
    gap("rd0");
    run_cmd(CMD_READ, 1'b0, 0, 0, 0, 0, 0, 0, n);
    check("rd1b_dout", bus.dout, 1);
    gap("rd1b");

    // Stretch: presc=2, slave holds SCL for 10 cycles from start of PH_B.
    presc = 16'd2;
    run_cmd(CMD_WRITE, 1'b1, 4, 13, 0, 0, 0, 0, n);
    check("str_cycles", n, 22);
    check("str_al", al_seen, 0);
    check("str_ph_a", scl_tr[3], 0);
    check("str_ph_b_end", scl_tr[16], 1);
    check("str_ph_c", {scl_tr[17], scl_tr[19]}, 2'b11);
    check("str_ph_d", scl_tr[20], 0);
    check("str_dout_hold", bus.dout, 1);
    gap("str");

    // Arbitration loss: WRITE 1, SDA pulled low in PH_B.
    presc = 16'd1;
    run_cmd(CMD_WRITE, 1'b1, 0, 0, 3, 4, 0, 0, n);
    check("al_cycle", n, 3);
    check("al_pulse", al_seen, 1);
    check("al_release", {bus.scl_oen, bus.sda_oen}, 2'b11);
    check("al_no_ack", bus.cmd_ack, 0);
    gap("al");
    ack_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      ack_seen |= bus.cmd_ack;
    end
    check("al_idle_no_ack", ack_seen, 0);

    // Reset during PH_C of STOP.
    bus.cmd = CMD_STOP;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_in_ph_c", {bus.scl_oen, bus.sda_oen}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_lines", {bus.scl_oen, bus.sda_oen}, 2'b11);
    check("rst_mid_ack", bus.cmd_ack, 0);
    ack_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      ack_seen |= bus.cmd_ack;
    end
    check("rst_mid_no_ack", ack_seen, 0);

    // ena low for 5 cycles in PH_B of WRITE 0: completes 5 cycles late.
    run_cmd(CMD_WRITE, 1'b0, 0, 0, 0, 0, 3, 7, n);
    check("ena_cycles", n, 13);
    check("ena_ph_a", scl_tr[2], 0);
    check("ena_ph_b", {scl_tr[3], scl_tr[9]}, 2'b11);
    check("ena_ph_c", scl_tr[10], 1);
    check("ena_ph_d", scl_tr[12], 0);
    check("ena_sda", {sda_tr[1], sda_tr[6], sda_tr[13]}, 3'b000);
    gap("ena");

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/i2c_bit_ctrl.md
Name: i2c_bit_ctrl

Overview:
Bit-level I2C master sequencer. It drives the open-drain SCL/SDA enables and reads back the filtered and synchronised bus lines produced by the team's line-filter block. It executes one bus command at a time (START, STOP, WRITE bit, READ bit), each split into four timed phases. It also handles clock stretching, detects arbitration loss, and tracks bus-busy, so a byte-level controller can sit above it.

Parameters:
PRESC_W, 16, width of the phase prescaler input
PHASES, 4, phases per command (fixed; a parameter only for readability)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ena  in  1  core enable; when 0, the prescaler and FSM hold
presc  in  PRESC_W  phase length minus one, in enabled clk cycles
cmd  in  3  command: 001 START, 010 STOP, 011 WRITE, 100 READ, others NOP
cmd_valid  in  1  command request
din  in  1  bit to transmit for WRITE
cmd_ack  out  1  one-cycle pulse when a command completes
dout  out  1  bit sampled by READ
al  out  1  one-cycle pulse on arbitration lost
busy  out  1  bus busy (START seen, STOP not yet seen)
scl_i  in  1  filtered SCL line
sda_i  in  1  filtered SDA line
scl_oen  out  1  SCL output enable, active-low (0 = drive low, 1 = release)
sda_oen  out  1  SDA output enable, active-low

Behaviour:
- Reset: on rst=1 at a clk edge, all outputs are set to scl_oen=1, sda_oen=1, cmd_ack=0, al=0, dout=0, busy=0. The FSM goes to IDLE and the prescaler to 0. Reset mid-command aborts the command with no ack, and both lines are released on the next edge.
- States: IDLE, PH_A, PH_B, PH_C, PH_D. Every line output is registered.
- Acceptance: in IDLE with cmd_valid=1, cmd_ack=0, ena=1 and cmd not NOP, the block latches cmd and din and enters PH_A. NOP with cmd_valid=1 is ignored with no ack.
- Phase timing: each phase lasts presc+1 cycles with ena=1. presc is sampled at each phase start. presc=0 gives 1-cycle phases.
- Line levels per phase (scl,sda), 1 = released:
  - START: A (1,1), B (1,1), C (1,0), D (0,0)
  - STOP: A (0,0), B (1,0), C (1,0), D (1,1)
  - WRITE: A (0,d), B (1,d), C (1,d), D (0,d)
  - READ: A (0,1), B (1,1), C (1,1), D (0,1)
- Outputs update on the edge that enters each phase.
- READ sampling: dout <= sda_i on the final cycle of PH_C. dout holds its value until the next READ.
- Completion: at the end of PH_D the FSM returns to IDLE and pulses cmd_ack for 1 cycle. The next command can be accepted no earlier than the cycle after cmd_ack, so back-to-back commands have a 1-cycle IDLE gap. Line levels from PH_D persist in IDLE.
- Clock stretching: in any phase where scl_oen=1 and scl_i=0, the prescaler freezes and the phase is extended. Counting resumes on the cycle after scl_i=1 is observed.
- Arbitration lost: if sda_oen=1 and sda_i=0 while in PH_B or PH_C of WRITE with d=1, or in PH_C of START, then:
  - al pulses for 1 cycle;
  - both lines are released on the same edge;
  - the FSM goes to IDLE with no cmd_ack.
- Bus monitor (independent of the FSM, uses the previous-cycle sda_i):
  - START condition = sda_i falls while scl_i=1; sets busy.
  - STOP condition = sda_i rises while scl_i=1; clears busy.
  - Both are detected regardless of ena.
- Simultaneous events: rst has priority over everything. Arbitration loss has priority over phase completion in the same cycle. A stretch freeze takes effect even on the cycle the count expires.
- Counter: an unsigned PRESC_W-bit down-counter reloaded from presc; it never wraps below 0.

Decomposition:
- Shared package i2c_pkg holds:
  - command codes CMD_NOP/START/STOP/WRITE/READ (3-bit);
  - FSM state enum;
  - PRESC_W default.
- One sub-module, i2c_bus_mon: edge detection on scl_i/sda_i, producing start_det, stop_det and busy.

Test Plan:
1. presc=3, ena=1, START then STOP with lines looped back → each command takes 16 cycles plus ack; sda falls in PH_C while scl=1; busy goes 1 after START and 0 after STOP; cmd_ack pulses twice.
2. WRITE din=0 then din=1, presc=0 → sda_oen=0 across all 4 phases, then 1; scl_oen sequence 0,1,1,0; cmd_ack on cycle 5 after acceptance.
3. READ with sda_i forced 0 in PH_C, presc=1 → dout=0; repeat with sda_i=1 → dout=1; cmd_ack after 8 cycles.
4. WRITE din=1, presc=2, scl_i held 0 for 10 cycles in PH_B → PH_B lasts 13 cycles; total command 22 cycles; no al.
5. WRITE din=1 with sda_i forced 0 in PH_B → al pulses once, scl_oen=sda_oen=1 next cycle, no cmd_ack, FSM IDLE.
6. rst asserted in PH_C of STOP, and ena=0 for 5 cycles mid-WRITE → reset values next edge with no ack; the ena-gated command completes 5 cycles late with correct levels.
